// File: rtl/dongwon_burst_ram_if.sv
// Request/response bus for dongwon_burst_ram.
// With DWRAM_PARITY_EN defined the bus also carries the test-only force_perr input.
interface dongwon_burst_ram_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_BYTES = 4
);
  localparam int DATA_WIDTH = 8 * WORD_BYTES;

  logic                  run;
  logic                  we;
  logic                  burst;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WORD_BYTES-1:0] wstrb;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  ready;
  logic                  busy;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  par_err;
`ifdef DWRAM_PARITY_EN
  logic                  force_perr;

  modport master (
    output run, we, burst, addr, wstrb, in_data, force_perr,
    input  ready, busy, out_data, out_valid, out_last, par_err
  );
  modport slave (
    input  run, we, burst, addr, wstrb, in_data, force_perr,
    output ready, busy, out_data, out_valid, out_last, par_err
  );
`else
  modport master (
    output run, we, burst, addr, wstrb, in_data,
    input  ready, busy, out_data, out_valid, out_last, par_err
  );
  modport slave (
    input  run, we, burst, addr, wstrb, in_data,
    output ready, busy, out_data, out_valid, out_last, par_err
  );
`endif
endinterface

// File: rtl/dongwon_burst_ram.sv
// Byte-addressed little-endian RAM with byte strobes, burst reads and a post-reset clear engine.
// Optional per-byte even parity is enabled with DWRAM_PARITY_EN.
module dongwon_burst_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_SIZE   = 4096,
  parameter int WORD_BYTES = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                clk,
  input  logic                reset,
  dongwon_burst_ram_if.slave  bus
);
  localparam int DATA_WIDTH = 8 * WORD_BYTES;
  localparam int NWORDS     = MEM_SIZE / WORD_BYTES;
  localparam int WSH        = $clog2(WORD_BYTES);
  localparam int CPW        = ADDR_WIDTH - WSH;
  localparam int CW         = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {CLEAR, IDLE, BURST} state_e;

  state_e                state_q;
  logic [CPW-1:0]        clr_ptr_q;
  logic [CW-1:0]         beat_q;
  logic [ADDR_WIDTH-1:0] baddr_q;
  logic                  ready_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic                  par_err_q;

  logic [7:0]            ram_q [MEM_SIZE];
`ifdef DWRAM_PARITY_EN
  logic                  par_q [MEM_SIZE];
`endif

  logic                  accept;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] clr_base;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_perr;

  assign accept   = (state_q == IDLE) && ready_q && bus.run;
  assign wr_en    = accept && bus.we && !reset;
  assign rd_addr  = (state_q == BURST) ? baddr_q : bus.addr;
  assign clr_base = ADDR_WIDTH'(clr_ptr_q) << WSH;

  always_comb begin
    rd_word = '0;
    rd_perr = 1'b0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      rd_word[8*i +: 8] = ram_q[rd_addr + ADDR_WIDTH'(i)];
`ifdef DWRAM_PARITY_EN
      rd_perr = rd_perr | (^ram_q[rd_addr + ADDR_WIDTH'(i)] ^ par_q[rd_addr + ADDR_WIDTH'(i)]);
`endif
    end
  end

  // Storage has no reset; the clear engine zeroes it word by word after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
          ram_q[clr_base + ADDR_WIDTH'(i)] <= '0;
`ifdef DWRAM_PARITY_EN
          par_q[clr_base + ADDR_WIDTH'(i)] <= 1'b0;
`endif
        end
      end else if (wr_en) begin
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
          if (bus.wstrb[i]) begin
            ram_q[bus.addr + ADDR_WIDTH'(i)] <= bus.in_data[8*i +: 8];
`ifdef DWRAM_PARITY_EN
            par_q[bus.addr + ADDR_WIDTH'(i)] <= (^bus.in_data[8*i +: 8]) ^ bus.force_perr;
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= '0;
      beat_q      <= '0;
      baddr_q     <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      par_err_q   <= 1'b0;
      case (state_q)
        CLEAR: begin
          clr_ptr_q <= clr_ptr_q + CPW'(1);
          if (clr_ptr_q == CPW'(NWORDS - 1)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (accept && !bus.we) begin
            out_data_q  <= rd_word;
            out_valid_q <= 1'b1;
            par_err_q   <= rd_perr;
            if (bus.burst) begin
              state_q <= BURST;
              ready_q <= 1'b0;
              beat_q  <= CW'(1);
              baddr_q <= bus.addr + ADDR_WIDTH'(WORD_BYTES);
            end else begin
              out_last_q <= 1'b1;
            end
          end
        end
        BURST: begin
          // beat_q counts beats already issued; one idle cycle follows the last beat
          if (beat_q == CW'(BURST_LEN)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            out_data_q  <= rd_word;
            out_valid_q <= 1'b1;
            par_err_q   <= rd_perr;
            out_last_q  <= (beat_q == CW'(BURST_LEN - 1));
            beat_q      <= beat_q + CW'(1);
            baddr_q     <= baddr_q + ADDR_WIDTH'(WORD_BYTES);
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.par_err   = par_err_q;
endmodule

// File: tb/tb_dongwon_burst_ram.sv
// Directed bench for dongwon_burst_ram at default parameters.
module tb_dongwon_burst_ram;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dongwon_burst_ram_if #(.ADDR_WIDTH(12), .WORD_BYTES(4)) bus ();

  dongwon_burst_ram #(
    .ADDR_WIDTH(12),
    .MEM_SIZE  (4096),
    .WORD_BYTES(4),
    .BURST_LEN (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        we;
    logic        burst;
    logic [11:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic burst, input logic [11:0] addr,
                       input logic [3:0] strb, input logic [31:0] data);
    bus.run     = 1'b1;
    bus.we      = we;
    bus.burst   = burst;
    bus.addr    = addr;
    bus.wstrb   = strb;
    bus.in_data = data;
  endtask

  task automatic single_read(input string nm, input logic [11:0] addr, input logic [31:0] exp);
    drive(1'b0, 1'b0, addr, 4'h0, 32'h0);
    step();
    bus.run = 1'b0;
    chk({nm, "_data"}, bus.out_data, exp);
    chk({nm, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
    chk({nm, "_last"}, {31'b0, bus.out_last}, 32'd1);
  endtask

  task automatic burst_read(input string nm, input logic [11:0] addr,
                            input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e = '{e0, e1, e2, e3};
    drive(1'b0, 1'b1, addr, 4'h0, 32'h0);
    step();
    bus.run = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_beat%0d_data", nm, k), bus.out_data, e[k]);
      chk($sformatf("%s_beat%0d_valid", nm, k), {31'b0, bus.out_valid}, 32'd1);
      chk($sformatf("%s_beat%0d_last", nm, k), {31'b0, bus.out_last}, (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("%s_beat%0d_ready", nm, k), {31'b0, bus.ready}, 32'd0);
      step();
    end
    chk({nm, "_after_valid"}, {31'b0, bus.out_valid}, 32'd0);
    chk({nm, "_after_last"}, {31'b0, bus.out_last}, 32'd0);
    chk({nm, "_after_ready"}, {31'b0, bus.ready}, 32'd1);
    chk({nm, "_after_hold"}, bus.out_data, e3);
  endtask

  initial begin
    int n;
    logic seen;

    // op, burst, addr, strb, data, expected read data
    vecs.push_back('{1'b0, 1'b0, 12'h000, 4'h0, 32'h0,        32'h00000000});
    vecs.push_back('{1'b1, 1'b0, 12'h100, 4'hF, 32'hDDCCBBAA, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 12'h100, 4'h0, 32'h0,        32'hDDCCBBAA});
    vecs.push_back('{1'b1, 1'b0, 12'h200, 4'hF, 32'hFFFFFFFF, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 12'h200, 4'h5, 32'h11223344, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 12'h200, 4'h0, 32'h0,        32'hFF22FF44});
    vecs.push_back('{1'b1, 1'b0, 12'hFFE, 4'hF, 32'h44332211, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 12'hFFE, 4'h0, 32'h0,        32'h44332211});
    vecs.push_back('{1'b0, 1'b0, 12'h000, 4'h0, 32'h0,        32'h00004433});
    vecs.push_back('{1'b0, 1'b0, 12'hFFC, 4'h0, 32'h0,        32'h22110000});
    vecs.push_back('{1'b1, 1'b0, 12'h300, 4'h0, 32'hDEADBEEF, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 12'h300, 4'h0, 32'h0,        32'h00000000});
    vecs.push_back('{1'b1, 1'b0, 12'h101, 4'h2, 32'h00005500, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 12'h100, 4'h0, 32'h0,        32'hDD55BBAA});
    vecs.push_back('{1'b1, 1'b0, 12'h040, 4'hF, 32'h00000001, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 12'h044, 4'hF, 32'h00000002, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 12'h048, 4'hF, 32'h00000003, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 12'h04C, 4'hF, 32'h00000004, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 12'h044, 4'h0, 32'h0,        32'h00000002});

    bus.run = 1'b0; bus.we = 1'b0; bus.burst = 1'b0;
    bus.addr = '0; bus.wstrb = '0; bus.in_data = '0;
`ifdef DWRAM_PARITY_EN
    bus.force_perr = 1'b0;
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_busy", {31'b0, bus.busy}, 32'd1);
    chk("rst_ready", {31'b0, bus.ready}, 32'd0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_last", {31'b0, bus.out_last}, 32'd0);
    chk("rst_par_err", {31'b0, bus.par_err}, 32'd0);

    // A write attempted mid-clear must be ignored; row 0 reads it back as zero.
    n = 0; seen = 1'b0;
    while (bus.busy && n < 2000) begin
      if (bus.ready) seen = 1'b1;
      if (n == 600) drive(1'b1, 1'b0, 12'h000, 4'hF, 32'hFFFFFFFF);
      else bus.run = 1'b0;
      step();
      n++;
    end
    bus.run = 1'b0;
    chk("clear_cycles", n, 32'd1024);
    chk("clear_ready_low", {31'b0, seen}, 32'd0);
    chk("clear_done_ready", {31'b0, bus.ready}, 32'd1);

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].burst, vecs[i].addr, vecs[i].strb, vecs[i].data);
      step();
      if (!vecs[i].we) begin
        chk($sformatf("vec%0d_data", i), bus.out_data, vecs[i].exp);
        chk($sformatf("vec%0d_valid", i), {31'b0, bus.out_valid}, 32'd1);
        chk($sformatf("vec%0d_last", i), {31'b0, bus.out_last}, 32'd1);
        chk($sformatf("vec%0d_perr", i), {31'b0, bus.par_err}, 32'd0);
      end else begin
        chk($sformatf("vec%0d_wr_valid", i), {31'b0, bus.out_valid}, 32'd0);
        chk($sformatf("vec%0d_wr_ready", i), {31'b0, bus.ready}, 32'd1);
      end
    end
    bus.run = 1'b0;
    step();
    chk("idle_valid_low", {31'b0, bus.out_valid}, 32'd0);
    chk("idle_data_hold", bus.out_data, 32'h00000002);

    burst_read("burst40", 12'h040, 32'd1, 32'd2, 32'd3, 32'd4);
    burst_read("burstwrap", 12'hFF8, 32'h0, 32'h22110000, 32'h00004433, 32'h0);
    single_read("after_burst", 12'h048, 32'd3);

    // Reset while beat 2 (index 1) is on the bus aborts the burst.
    drive(1'b0, 1'b1, 12'h040, 4'h0, 32'h0);
    step();
    bus.run = 1'b0;
    chk("abort_beat0", bus.out_data, 32'd1);
    step();
    chk("abort_beat1", bus.out_data, 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("abort_last", {31'b0, bus.out_last}, 32'd0);
    chk("abort_busy", {31'b0, bus.busy}, 32'd1);
    chk("abort_ready", {31'b0, bus.ready}, 32'd0);
    n = 0; seen = 1'b0;
    while (bus.busy && n < 2000) begin
      if (bus.out_valid) seen = 1'b1;
      step();
      n++;
    end
    chk("abort_clear_cycles", n, 32'd1024);
    chk("abort_no_beats", {31'b0, seen}, 32'd0);
    single_read("cleared040", 12'h040, 32'h0);
    single_read("cleared100", 12'h100, 32'h0);
    single_read("clearedFFE", 12'hFFE, 32'h0);
    single_read("cleared200", 12'h200, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
